// File: rtl/sysid_pkg.sv
// Shared constants for the sysid_info_regs register slave: word map, CAPS layout, CONTROL bits.
// Also provides the CAPS word builder and the byte-lane merge used for SCRATCH.
package sysid_pkg;

    localparam int unsigned ADDR_SYSTEM_ID = 0;
    localparam int unsigned ADDR_TIMESTAMP = 1;
    localparam int unsigned ADDR_UPTIME_LO = 2;
    localparam int unsigned ADDR_UPTIME_HI = 3;
    localparam int unsigned ADDR_SCRATCH   = 4;
    localparam int unsigned ADDR_CAPS      = 5;
    localparam int unsigned ADDR_CONTROL   = 6;

    localparam logic [7:0]  CAPS_VERSION     = 8'h02;
    localparam int unsigned CAPS_UPTIME_BIT  = 0;
    localparam int unsigned CAPS_VERSION_LSB = 8;

    localparam int unsigned CTRL_CLEAR_BIT = 0;

    function automatic logic [31:0] caps_word(input logic uptime_present);
        logic [31:0] w;
        w = '0;
        w[CAPS_UPTIME_BIT] = uptime_present;
        w[CAPS_VERSION_LSB +: 8] = CAPS_VERSION;
        return w;
    endfunction

    function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  lanes);
        logic [31:0] w;
        w = old_word;
        for (int b = 0; b < 4; b++) begin
            if (lanes[b]) w[8*b +: 8] = new_word[8*b +: 8];
        end
        return w;
    endfunction

endpackage

// File: rtl/sysid_uptime_counter.sv
// Free-running 64-bit uptime counter advanced once every PRESCALE clocks; clear restarts prescaler and count.
// tick is high in the cycle the prescaler sits at PRESCALE-1; count updates on the following edge.
module sysid_uptime_counter #(
    parameter int unsigned PRESCALE = 50000
)(
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    output logic        tick,
    output logic [63:0] count
);

    localparam int unsigned PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_MAX = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0] prescale_cnt;

    assign tick = (prescale_cnt == PS_MAX);

    // Clear outranks a coincident tick so the count restarts from exactly 0.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            prescale_cnt <= '0;
            count        <= '0;
        end else if (tick) begin
            prescale_cnt <= '0;
            count        <= count + 64'd1;
        end else begin
            prescale_cnt <= prescale_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/sysid_info_regs.sv
// System-ID register slave: ID, timestamp, scratch, caps, optional uptime (SYSID_UPTIME_EN). Read latency 1, no waitrequest.
// Reading UPTIME_LO latches the high word into a snapshot so software gets a coherent 64-bit pair.
module sysid_info_regs
    import sysid_pkg::*;
#(
    parameter logic [31:0] SYSTEM_ID = 32'h0000_0000,
    parameter logic [31:0] TIMESTAMP = 32'd1537796191,
    parameter int unsigned PRESCALE  = 50000,
    parameter int unsigned ADDR_W    = 3
)(
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic              read,
    input  logic              write,
    input  logic [31:0]       writedata,
    input  logic [3:0]        byteenable,
    output logic [31:0]       readdata,
    output logic              readdatavalid
);

    logic        sel_uptime_lo;
    logic        sel_scratch;
    logic        sel_control;
    logic [31:0] scratch;
    logic [31:0] uptime_lo;
    logic [31:0] uptime_hi;
    logic [31:0] rd_mux;

    assign sel_uptime_lo = (address == ADDR_W'(ADDR_UPTIME_LO));
    assign sel_scratch   = (address == ADDR_W'(ADDR_SCRATCH));
    assign sel_control   = (address == ADDR_W'(ADDR_CONTROL));

`ifdef SYSID_UPTIME_EN
    localparam logic UPTIME_PRESENT = 1'b1;

    logic        uptime_clear;
    logic        uptime_tick;
    logic [63:0] uptime_count;
    logic [31:0] snapshot;

    assign uptime_clear = write && sel_control && writedata[CTRL_CLEAR_BIT];

    sysid_uptime_counter #(
        .PRESCALE (PRESCALE)
    ) u_uptime (
        .clock (clock),
        .reset (reset),
        .clear (uptime_clear),
        .tick  (uptime_tick),
        .count (uptime_count)
    );

    // Captures the pre-increment high word, matching the low word returned this cycle.
    always_ff @(posedge clock) begin
        if (reset || uptime_clear) begin
            snapshot <= '0;
        end else if (read && sel_uptime_lo) begin
            snapshot <= uptime_count[63:32];
        end
    end

    assign uptime_lo = uptime_count[31:0];
    assign uptime_hi = snapshot;
`else
    localparam logic UPTIME_PRESENT = 1'b0;

    assign uptime_lo = '0;
    assign uptime_hi = '0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            scratch <= '0;
        end else if (write && sel_scratch) begin
            scratch <= byte_merge(scratch, writedata, byteenable);
        end
    end

    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_W'(ADDR_SYSTEM_ID): rd_mux = SYSTEM_ID;
            ADDR_W'(ADDR_TIMESTAMP): rd_mux = TIMESTAMP;
            ADDR_W'(ADDR_UPTIME_LO): rd_mux = uptime_lo;
            ADDR_W'(ADDR_UPTIME_HI): rd_mux = uptime_hi;
            ADDR_W'(ADDR_SCRATCH):   rd_mux = scratch;
            ADDR_W'(ADDR_CAPS):      rd_mux = caps_word(UPTIME_PRESENT);
            default:                 rd_mux = '0;
        endcase
    end

    // readdata is forced to 0 whenever no read response is being presented.
    always_ff @(posedge clock) begin
        if (reset) begin
            readdata      <= '0;
            readdatavalid <= 1'b0;
        end else begin
            readdata      <= read ? rd_mux : '0;
            readdatavalid <= read;
        end
    end

endmodule
